// File: rtl/adder_seq_ctrl.sv
// ============================================================================
// adder_seq_ctrl : byte-serial multi-byte adder on one shared 8-bit adder
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       overflow
);
    logic [8:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
    assign sum      = w_full[7:0];
    assign overflow = w_full[8];
endmodule

module adder_seq_ctrl #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] a,
    input  logic [8*NUM_BYTES-1:0] b,
    input  logic                   carry_in,
    output logic                   busy,
    output logic                   done,
    output logic [8*NUM_BYTES-1:0] sum,
    output logic                   overflow
);
    localparam int W     = 8 * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_partial;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [IDX_W-1:0] r_idx;

    logic [IDX_W+2:0] w_shift;
    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;
    logic [7:0]       w_add_sum;
    logic             w_add_ovf;
    logic [W-1:0]     w_partial_next;

    assign w_shift  = {r_idx, 3'b000};
    assign w_a_byte = 8'(r_a >> w_shift);
    assign w_b_byte = 8'(r_b >> w_shift);

    adder_8bit u_adder (
        .a        (w_a_byte),
        .b        (w_b_byte),
        .carry_in (r_carry),
        .sum      (w_add_sum),
        .overflow (w_add_ovf)
    );

    // Partial sum with the current byte merged in, so the final edge can
    // publish the complete word in the same cycle it is formed.
    assign w_partial_next = (r_partial & ~(W'(8'hFF) << w_shift))
                          | (W'(w_add_sum) << w_shift);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= carry_in;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_partial <= w_partial_next;
                    r_carry   <= w_add_ovf;
                    r_idx     <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_sum   <= w_partial_next;
                        r_ovf   <= w_add_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign overflow = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
// ============================================================================
// tb_adder_seq_ctrl : scoreboard bench for 4-byte and 1-byte builds
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adder_seq_ctrl;
    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b, sum;
    logic        carry_in, busy, done, overflow;

    logic        start1;
    logic [7:0]  a1, b1, sum1;
    logic        cin1, busy1, done1, ovf1;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;
    int ndone = 0;

    typedef struct {
        logic [32:0] val;
        int          c;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        o;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    adder_seq_ctrl #(.NUM_BYTES(NB)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done),
        .sum(sum), .overflow(overflow)
    );

    adder_seq_ctrl #(.NUM_BYTES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .carry_in(cin1), .busy(busy1), .done(done1),
        .sum(sum1), .overflow(ovf1)
    );

    // Scoreboard monitor: every done pulse must match the oldest pending op.
    always @(negedge clk) begin
        exp_t e;
        cnt <= cnt + 1;
        if (done) begin
            ndone = ndone + 1;
            total = total + 1;
            if (q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_done: got done=1 at cnt %0d, required no pending op", cnt);
            end else begin
                e = q.pop_front();
                if ({overflow, sum} !== e.val) begin
                    bad = bad + 1;
                    $display("FAIL result: got ovf=%0b sum=%h, required ovf=%0b sum=%h",
                             overflow, sum, e.val[32], e.val[31:0]);
                end
                total = total + 1;
                if (cnt - e.c != NB + 1) begin
                    bad = bad + 1;
                    $display("FAIL latency: got %0d, required %0d", cnt - e.c, NB + 1);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        total = total + 1;
        if (got !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) break;
        end
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL timeout: got %0d pending ops, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                          input logic [32:0] ev);
        @(negedge clk);
        a = ta; b = tb; carry_in = tc; start = 1'b1;
        q.push_back('{val: ev, c: cnt});
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        int c0;
        int nd0;
        logic [31:0] ra, rb;
        logic        rc;
        logic [8:0]  e1;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[5] = '{32'h00FF00FF, 32'hFF00FF00, 1'b1, 32'h00000000, 1'b1};
        vecs[6] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
        vecs[7] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {30'd0, busy, done, sum}, 64'd0);
        check("reset_ovf", {63'd0, overflow}, 64'd0);
        rst = 1'b0;

        // First op with busy window and no partial values on sum.
        @(negedge clk);
        a = 32'h000000FF; b = 32'h1; carry_in = 1'b0; start = 1'b1;
        q.push_back('{val: {1'b0, 32'h00000100}, c: cnt});
        for (int i = 1; i <= NB; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("busy_in_add", {63'd0, busy}, 64'd1);
            check("sum_held_during_add", {32'd0, sum}, 64'd0);
        end
        @(negedge clk);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        wait_idle();

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].o, vecs[i].s});

        // Operands must be latched on the accepting edge.
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; carry_in = 1'b0; start = 1'b1;
        q.push_back('{val: {1'b0, 32'h23456789}, c: cnt});
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        wait_idle();

        // start held high: accepts every NB+2 cycles, nothing queued.
        @(negedge clk);
        c0 = cnt; nd0 = ndone;
        a = 32'h1; b = 32'h1; carry_in = 1'b0; start = 1'b1;
        for (int k = 0; k < 4; k++) q.push_back('{val: 33'd2, c: c0 + k * (NB + 2)});
        repeat (20) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        check("held_start_done_count", 64'(ndone - nd0), 64'd4);

        // Reset in the second ADD cycle discards the op.
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'h1; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midadd_reset_outputs", {30'd0, busy, done, sum}, 64'd0);
        check("midadd_reset_ovf", {63'd0, overflow}, 64'd0);
        nd0 = ndone;
        repeat (8) @(negedge clk);
        check("no_done_after_reset", 64'(ndone - nd0), 64'd0);
        run_op(32'd3, 32'd4, 1'b0, 33'd7);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = ~ra;
            run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'd0, rc});
        end

        // Single-byte build: ADD lasts one cycle, done two edges after start.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom_range(0, 1));
            e1 = {1'b0, a1} + {1'b0, b1} + {8'd0, cin1};
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check("nb1_busy", {62'd0, busy1, done1}, 64'd2);
            @(negedge clk);
            check("nb1_done", {62'd0, busy1, done1}, 64'd1);
            check("nb1_result", {55'd0, ovf1, sum1}, {55'd0, e1});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
